// File: rtl/fpu_op_issue_pkg.sv
// Shared FPU definitions: JVM FP opcode bytes, issue FSM state encoding and watchdog limit.
package fpu_op_issue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_KILL = 2'd3
  } issue_state_t;

  localparam logic [7:0] OP_FADD  = 8'h62;
  localparam logic [7:0] OP_DADD  = 8'h63;
  localparam logic [7:0] OP_FSUB  = 8'h66;
  localparam logic [7:0] OP_DSUB  = 8'h67;
  localparam logic [7:0] OP_FMUL  = 8'h6a;
  localparam logic [7:0] OP_DMUL  = 8'h6b;
  localparam logic [7:0] OP_FDIV  = 8'h6e;
  localparam logic [7:0] OP_DDIV  = 8'h6f;
  localparam logic [7:0] OP_FREM  = 8'h72;
  localparam logic [7:0] OP_DREM  = 8'h73;
  localparam logic [7:0] OP_I2F   = 8'h86;
  localparam logic [7:0] OP_I2D   = 8'h87;
  localparam logic [7:0] OP_L2F   = 8'h89;
  localparam logic [7:0] OP_L2D   = 8'h8a;
  localparam logic [7:0] OP_F2I   = 8'h8b;
  localparam logic [7:0] OP_F2L   = 8'h8c;
  localparam logic [7:0] OP_F2D   = 8'h8d;
  localparam logic [7:0] OP_D2I   = 8'h8e;
  localparam logic [7:0] OP_D2L   = 8'h8f;
  localparam logic [7:0] OP_D2F   = 8'h90;
  localparam logic [7:0] OP_FCMPL = 8'h95;
  localparam logic [7:0] OP_FCMPG = 8'h96;
  localparam logic [7:0] OP_DCMPL = 8'h97;
  localparam logic [7:0] OP_DCMPG = 8'h98;

  localparam logic [7:0] WD_LIMIT = 8'hFF;

endpackage

// File: rtl/fpu_op_classify.sv
// Combinational decode: is this JVM opcode one the FPU sequencer implements?
module fpu_op_classify
  import fpu_op_issue_pkg::*;
(
  input  logic [7:0] opcode,
  output logic       legal
);

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_FADD, OP_DADD, OP_FSUB, OP_DSUB, OP_FMUL, OP_DMUL,
      OP_FDIV, OP_DDIV, OP_FREM, OP_DREM,
      OP_I2F, OP_I2D, OP_L2F, OP_L2D, OP_F2I, OP_F2L,
      OP_F2D, OP_D2I, OP_D2L, OP_D2F,
      OP_FCMPL, OP_FCMPG, OP_DCMPL, OP_DCMPG: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/fpu_op_issue.sv
// Issues one FP opcode at a time from the IU to the FPU microcode sequencer.
// Optional WAIT watchdog enabled by defining FPU_ISSUE_WATCHDOG_EN.
module fpu_op_issue
  import fpu_op_issue_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       iu_op_valid,
  input  logic [7:0] iu_opcode,
  output logic       iu_op_ready,
  input  logic       iu_op_kill,
  input  logic       iu_stall,
  output logic [7:0] nx_opcode,
  output logic       nx_fpop_valid,
  input  logic       fpu_look,
  input  logic       fpu_done,
  output logic       fpuhold,
  output logic       fpkill,
  output logic       iu_res_valid,
  output logic       iu_op_illegal,
  output logic       iu_timeout,
  output logic       busy,
  output logic [1:0] dbg_state,
  output logic [7:0] dbg_opcode
);

  // Handshake: an opcode transfers on a cycle where iu_op_valid and iu_op_ready are both 1;
  // iu_op_ready never depends on iu_op_valid.
  issue_state_t state, state_nx;
  logic [7:0]   op_q;
  logic         res_q, ill_q;
  logic         legal, accept, kill_active, timeout;

  fpu_op_classify u_classify (
    .opcode (iu_opcode),
    .legal  (legal)
  );

  assign accept      = iu_op_valid && iu_op_ready;
  assign kill_active = iu_op_kill && (state == ST_SEND || state == ST_WAIT);

`ifdef FPU_ISSUE_WATCHDOG_EN
  logic [7:0] wd_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= 8'h00;
    end else if (state == ST_SEND && state_nx == ST_WAIT) begin
      wd_cnt <= 8'h00;
    end else if (state == ST_WAIT && !iu_stall && !timeout) begin
      wd_cnt <= wd_cnt + 8'h01;
    end
  end

  // An external kill takes precedence; the timeout only fires on an unheld cycle.
  assign timeout = (state == ST_WAIT) && (wd_cnt == WD_LIMIT) && !iu_stall && !iu_op_kill;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept && legal) state_nx = ST_SEND;
      ST_SEND: begin
        if (kill_active)                state_nx = ST_KILL;
        else if (!iu_stall && fpu_look) state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (kill_active || timeout)     state_nx = ST_KILL;
        else if (!iu_stall && fpu_done) state_nx = ST_IDLE;
      end
      ST_KILL: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    iu_op_ready   = (state == ST_IDLE) && !iu_stall && !iu_op_kill;
    nx_fpop_valid = (state == ST_SEND);
    nx_opcode     = nx_fpop_valid ? op_q : 8'h00;
    fpuhold       = iu_stall;
    fpkill        = reset || kill_active || timeout;
    busy          = (state != ST_IDLE);
    iu_timeout    = timeout;
    iu_res_valid  = res_q;
    iu_op_illegal = ill_q;
    dbg_state     = state;
    dbg_opcode    = op_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q  <= 8'h00;
      res_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      res_q <= (state == ST_WAIT) && fpu_done && !iu_stall && !kill_active && !timeout;
      ill_q <= accept && !legal;
      if (accept && legal) op_q <= iu_opcode;
    end
  end

endmodule

// File: tb/tb_fpu_op_issue.sv
// Self-checking bench for fpu_op_issue: directed scenarios with literal checks plus a random run
// compared every cycle against a behavioural model.
module tb_fpu_op_issue;
  import fpu_op_issue_pkg::*;

`ifdef FPU_ISSUE_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  localparam int M_IDLE = 0, M_SEND = 1, M_WAIT = 2, M_KILL = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b0, iu_op_valid = 1'b0, iu_op_kill = 1'b0, iu_stall = 1'b0;
  logic       fpu_look = 1'b0, fpu_done = 1'b0;
  logic [7:0] iu_opcode = 8'h00;
  logic       iu_op_ready, nx_fpop_valid, fpuhold, fpkill, iu_res_valid, iu_op_illegal;
  logic       iu_timeout, busy;
  logic [7:0] nx_opcode, dbg_opcode;
  logic [1:0] dbg_state;

  fpu_op_issue dut (
    .clk(clk), .reset(reset), .iu_op_valid(iu_op_valid), .iu_opcode(iu_opcode),
    .iu_op_ready(iu_op_ready), .iu_op_kill(iu_op_kill), .iu_stall(iu_stall),
    .nx_opcode(nx_opcode), .nx_fpop_valid(nx_fpop_valid), .fpu_look(fpu_look),
    .fpu_done(fpu_done), .fpuhold(fpuhold), .fpkill(fpkill), .iu_res_valid(iu_res_valid),
    .iu_op_illegal(iu_op_illegal), .iu_timeout(iu_timeout), .busy(busy),
    .dbg_state(dbg_state), .dbg_opcode(dbg_opcode)
  );

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  logic [7:0] legal_ops [24] = '{8'h62, 8'h63, 8'h66, 8'h67, 8'h6a, 8'h6b, 8'h6e, 8'h6f,
                                  8'h72, 8'h73, 8'h86, 8'h87, 8'h89, 8'h8a, 8'h8b, 8'h8c,
                                  8'h8d, 8'h8e, 8'h8f, 8'h90, 8'h95, 8'h96, 8'h97, 8'h98};

  function automatic bit is_legal(input logic [7:0] op);
    for (int i = 0; i < 24; i++) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] st_code(input int s);
    case (s)
      M_SEND:  return ST_SEND;
      M_WAIT:  return ST_WAIT;
      M_KILL:  return ST_KILL;
      default: return ST_IDLE;
    endcase
  endfunction

  // Behavioural model: phase of the single in-flight op plus registered pulses.
  int         m_st = M_IDLE, m_cnt = 0;
  logic [7:0] m_op = 8'h00;
  bit         m_res = 0, m_ill = 0, m_init = 0;
  logic [7:0] exp_q [$];

  initial begin : compare
    bit e_ready, e_tmo, e_kill, in_op;
    forever begin
      @(negedge clk);
      #2;
      in_op   = (m_st == M_SEND || m_st == M_WAIT);
      e_ready = (m_st == M_IDLE) && !iu_stall && !iu_op_kill;
      e_tmo   = WD && (m_st == M_WAIT) && (m_cnt == 255) && !iu_stall && !iu_op_kill;
      e_kill  = reset || (iu_op_kill && in_op) || e_tmo;
      if (m_init) begin
        chk("ready", iu_op_ready, e_ready);
        chk("fpuhold", fpuhold, iu_stall);
        chk("fpkill", fpkill, e_kill);
        chk("timeout", iu_timeout, e_tmo);
        chk("res_valid", iu_res_valid, m_res);
        chk("illegal", iu_op_illegal, m_ill);
        chk("busy", busy, m_st != M_IDLE);
        chk("state", dbg_state, st_code(m_st));
        chk("opreg", dbg_opcode, m_op);
        chk("nx_valid", nx_fpop_valid, m_st == M_SEND);
        if (m_st == M_SEND) chk("nx_opcode", nx_opcode, exp_q[0]);
        else                chk("nx_opcode_zero", nx_opcode, 8'h00);
      end
      if (reset) begin
        m_st = M_IDLE; m_op = 8'h00; m_cnt = 0; m_res = 0; m_ill = 0; m_init = 1;
        exp_q.delete();
      end else begin
        m_res = 0; m_ill = 0;
        case (m_st)
          M_IDLE: if (e_ready && iu_op_valid) begin
            if (is_legal(iu_opcode)) begin
              m_op = iu_opcode; exp_q.push_back(iu_opcode); m_st = M_SEND;
            end else m_ill = 1;
          end
          M_SEND: begin
            if (iu_op_kill) begin
              m_st = M_KILL; void'(exp_q.pop_front());
            end else if (!iu_stall && fpu_look) begin
              m_st = M_WAIT; m_cnt = 0; void'(exp_q.pop_front());
            end
          end
          M_WAIT: begin
            if (iu_op_kill || e_tmo) m_st = M_KILL;
            else if (!iu_stall) begin
              if (fpu_done) begin m_res = 1; m_st = M_IDLE; end
              else m_cnt++;
            end
          end
          default: m_st = M_IDLE;
        endcase
      end
    end
  end

  task automatic step(input bit r, input bit v, input logic [7:0] op, input bit k,
                      input bit s, input bit l, input bit d);
    @(negedge clk);
    reset = r; iu_op_valid = v; iu_opcode = op; iu_op_kill = k;
    iu_stall = s; fpu_look = l; fpu_done = d;
    #3;
  endtask

  task automatic idle();
    step(0, 0, 8'h00, 0, 0, 0, 0);
  endtask

  initial begin : main
    int n;
    // fadd through the full issue path
    step(1, 0, 8'h00, 0, 0, 0, 0);
    chk("lit_rst_fpkill", fpkill, 1'b1);
    idle();
    chk("lit_post_rst_busy", busy, 1'b0);
    chk("lit_post_rst_fpkill", fpkill, 1'b0);
    chk("lit_post_rst_nxv", nx_fpop_valid, 1'b0);
    chk("lit_post_rst_pulses", {iu_res_valid, iu_op_illegal, iu_timeout}, 3'b000);
    step(0, 1, 8'h62, 0, 0, 0, 0);
    chk("lit_fadd_ready", iu_op_ready, 1'b1);
    idle();
    chk("lit_send_nxv", nx_fpop_valid, 1'b1);
    chk("lit_send_nxop", nx_opcode, 8'h62);
    step(0, 0, 8'h00, 0, 0, 1, 0);
    idle();
    chk("lit_wait_nxop", nx_opcode, 8'h00);
    chk("lit_wait_busy", busy, 1'b1);
    step(0, 0, 8'h00, 0, 0, 0, 1);
    idle();
    chk("lit_res_pulse", iu_res_valid, 1'b1);
    chk("lit_res_busy", busy, 1'b0);
    idle();
    chk("lit_res_one_cycle", iu_res_valid, 1'b0);

    // iadd is not an FP op
    step(0, 1, 8'h60, 0, 0, 0, 0);
    idle();
    chk("lit_ill_pulse", iu_op_illegal, 1'b1);
    chk("lit_ill_nxv", nx_fpop_valid, 1'b0);
    chk("lit_ill_busy", busy, 1'b0);

    // ddiv killed in WAIT together with fpu_done
    step(0, 1, 8'h6f, 0, 0, 0, 0);
    step(0, 0, 8'h00, 0, 0, 1, 0);
    step(0, 0, 8'h00, 1, 0, 0, 1);
    chk("lit_kill_fpkill", fpkill, 1'b1);
    idle();
    chk("lit_kill_state", dbg_state, ST_KILL);
    chk("lit_kill_nores", iu_res_valid, 1'b0);
    idle();
    chk("lit_kill_idle", busy, 1'b0);
    chk("lit_kill_nores2", iu_res_valid, 1'b0);

    // fmul held in SEND by iu_stall
    step(0, 1, 8'h6a, 0, 0, 0, 0);
    repeat (3) begin
      step(0, 0, 8'h00, 0, 1, 1, 0);
      chk("lit_stall_hold", fpuhold, 1'b1);
      chk("lit_stall_send", dbg_state, ST_SEND);
    end
    step(0, 0, 8'h00, 0, 0, 1, 0);
    chk("lit_release_send", dbg_state, ST_SEND);
    idle();
    chk("lit_release_wait", dbg_state, ST_WAIT);
    step(0, 0, 8'h00, 0, 0, 0, 1);
    idle();

    // reset while in WAIT
    step(0, 1, 8'h62, 0, 0, 0, 0);
    step(0, 0, 8'h00, 0, 0, 1, 0);
    step(1, 0, 8'h00, 0, 0, 0, 1);
    chk("lit_rstwait_fpkill", fpkill, 1'b1);
    idle();
    chk("lit_rstwait_idle", busy, 1'b0);
    chk("lit_rstwait_opreg", dbg_opcode, 8'h00);
    chk("lit_rstwait_pulses", {iu_res_valid, iu_op_illegal, iu_timeout}, 3'b000);

`ifdef FPU_ISSUE_WATCHDOG_EN
    // fcmpl never completes: watchdog fires on the WAIT cycle after 255 unheld cycles
    step(0, 1, 8'h95, 0, 0, 0, 0);
    step(0, 0, 8'h00, 0, 0, 1, 0);
    n = 0;
    while (n < 300) begin
      idle();
      n++;
      if (iu_timeout) break;
    end
    chk("lit_wd_cycles", n, 256);
    chk("lit_wd_fpkill", fpkill, 1'b1);
    idle();
    chk("lit_wd_kill", dbg_state, ST_KILL);
    idle();
    chk("lit_wd_idle", busy, 1'b0);
`else
    n = 0;
`endif

    // randomized traffic against the model
    repeat (4000) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 9) < 7) ? legal_ops[$urandom_range(0, 23)]
                                      : 8'($urandom_range(0, 255)),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 3) == 0));
    end
    repeat (4) idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : time_limit
    #1000000;
    $display("FAIL time_limit: simulation exceeded %0t", $time);
    $fatal(1);
  end

endmodule
